// File: rtl/stopwatch_core_pkg.sv
// Shared definitions for the stopwatch: FSM encoding and digit limits.
package stopwatch_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    localparam int CSEC_MAX = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;

    // Width of the prescaler; covers the full legal USEC_PER_CSEC range.
    localparam int PRESC_W  = 14;

endpackage

// File: rtl/stopwatch_core_counter_modn.sv
// Modulo-N counter stage: enable in, synchronous clear, combinational carry out
// asserted on the enabled cycle that wraps the count back to zero.
module counter_modn #(
    parameter int MODULUS = 10,
    parameter int W       = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         carry_o
);

    localparam logic [W-1:0] TERM = W'(MODULUS - 1);

    logic [W-1:0] cnt_q;

    assign carry_o = en_i && (cnt_q == TERM);
    assign cnt_o   = cnt_q;

    // Count on enable, wrap at terminal count; clear wins over enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (en_i)
            cnt_q <= (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: run/pause/idle FSM, microsecond prescaler, csec/sec/min
// digit chain and a lap hold register that freezes the display.
module stopwatch_core
    import stopwatch_core_pkg::*;
#(
    parameter int USEC_PER_CSEC = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_usec,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [6:0] csec,
    output logic       running,
    output logic       lap_active,
    output logic       sec_pulse
);

    sw_state_e    state_q;
    logic         running_q;
    logic         lap_q;
    logic         sec_pulse_q;
    logic [5:0]   hold_min_q, hold_sec_q;
    logic [6:0]   hold_csec_q;

    logic [PRESC_W-1:0] presc_cnt;
    logic [6:0]   live_csec;
    logic [5:0]   live_sec, live_min;
    logic         count_en, csec_tick, sec_tick, min_tick, min_wrap;

    // Uses the current state, so a pulse on the RUN->PAUSE edge still counts
    // and a pulse on the edge that enters RUN does not.
    assign count_en = (state_q == ST_RUN) && clk_usec && !btn_clear;

    counter_modn #(.MODULUS(USEC_PER_CSEC), .W(PRESC_W)) u_presc (
        .clk(clk), .reset(reset), .clr_i(btn_clear), .en_i(count_en),
        .cnt_o(presc_cnt), .carry_o(csec_tick)
    );

    counter_modn #(.MODULUS(CSEC_MAX + 1), .W(7)) u_csec (
        .clk(clk), .reset(reset), .clr_i(btn_clear), .en_i(csec_tick),
        .cnt_o(live_csec), .carry_o(sec_tick)
    );

    counter_modn #(.MODULUS(SEC_MAX + 1), .W(6)) u_sec (
        .clk(clk), .reset(reset), .clr_i(btn_clear), .en_i(sec_tick),
        .cnt_o(live_sec), .carry_o(min_tick)
    );

    // Minute carry is unused: 59:59.99 simply wraps to zero and keeps going.
    counter_modn #(.MODULUS(MIN_MAX + 1), .W(6)) u_min (
        .clk(clk), .reset(reset), .clr_i(btn_clear), .en_i(min_tick),
        .cnt_o(live_min), .carry_o(min_wrap)
    );

    // Run/pause FSM with registered running flag; clear overrides everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
        end else if (btn_clear) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
        end else if (btn_start_stop) begin
            case (state_q)
                ST_IDLE:  begin state_q <= ST_RUN;   running_q <= 1'b1; end
                ST_RUN:   begin state_q <= ST_PAUSE; running_q <= 1'b0; end
                ST_PAUSE: begin state_q <= ST_RUN;   running_q <= 1'b1; end
                default:  begin state_q <= ST_IDLE;  running_q <= 1'b0; end
            endcase
        end
    end

    // Lap toggle only while running; setting it snapshots the live time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_q       <= 1'b0;
            hold_min_q  <= '0;
            hold_sec_q  <= '0;
            hold_csec_q <= '0;
        end else if (btn_clear) begin
            lap_q       <= 1'b0;
            hold_min_q  <= '0;
            hold_sec_q  <= '0;
            hold_csec_q <= '0;
        end else if (btn_lap && state_q == ST_RUN) begin
            lap_q <= !lap_q;
            if (!lap_q) begin
                hold_min_q  <= live_min;
                hold_sec_q  <= live_sec;
                hold_csec_q <= live_csec;
            end
        end
    end

    // One-cycle flag after each seconds increment, regardless of lap freeze.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sec_pulse_q <= 1'b0;
        else
            sec_pulse_q <= sec_tick;
    end

    assign min        = lap_q ? hold_min_q  : live_min;
    assign sec        = lap_q ? hold_sec_q  : live_sec;
    assign csec       = lap_q ? hold_csec_q : live_csec;
    assign running    = running_q;
    assign lap_active = lap_q;
    assign sec_pulse  = sec_pulse_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with a short prescaler (4 pulses/csec).
module tb_stopwatch_core;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_usec = 1'b0;
    logic       btn_start_stop = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clear = 1'b0;
    logic [5:0] min, sec;
    logic [6:0] csec;
    logic       running, lap_active, sec_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_core #(.USEC_PER_CSEC(P)) dut (
        .clk(clk), .reset(reset), .clk_usec(clk_usec),
        .btn_start_stop(btn_start_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .min(min), .sec(sec), .csec(csec),
        .running(running), .lap_active(lap_active), .sec_pulse(sec_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int m, input int s, input int c);
        check({tag, ".min"},  32'(min),  32'(m));
        check({tag, ".sec"},  32'(sec),  32'(s));
        check({tag, ".csec"}, 32'(csec), 32'(c));
    endtask

    // n consecutive cycles with clk_usec high
    task automatic pulses(input int n);
        if (n > 0) begin
            @(negedge clk);
            clk_usec = 1'b1;
            repeat (n) @(negedge clk);
            clk_usec = 1'b0;
        end
    endtask

    // One cycle with the given inputs asserted
    task automatic drive(input logic ss, input logic lap, input logic clr, input logic us);
        @(negedge clk);
        btn_start_stop = ss; btn_lap = lap; btn_clear = clr; clk_usec = us;
        @(negedge clk);
        btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0; clk_usec = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check_time("rst", 0, 0, 0);
        check("rst.running", 32'(running), 0);
        check("rst.lap", 32'(lap_active), 0);
        check("rst.sec_pulse", 32'(sec_pulse), 0);
        reset = 1'b0;
        pulses(10);
        check_time("idle_no_count", 0, 0, 0);

        // start and first centisecond
        drive(1, 0, 0, 0);
        check("start.running", 32'(running), 1);
        pulses(P - 1);
        check("presc_below_term", 32'(csec), 0);
        pulses(1);
        check("first_csec", 32'(csec), 1);

        // pause keeps sub-centisecond progress
        pulses(2);
        drive(1, 0, 0, 0);
        check("pause.running", 32'(running), 0);
        pulses(20);
        check("pause_hold", 32'(csec), 1);
        drive(1, 0, 0, 0);
        pulses(2);
        check("resume_keeps_presc", 32'(csec), 2);

        // pulse coincident with RUN->PAUSE counts; with PAUSE->RUN it does not
        drive(1, 0, 0, 1);
        pulses(3);
        drive(1, 0, 0, 1);
        pulses(2);
        check("edge_pulses_a", 32'(csec), 2);
        pulses(1);
        check("edge_pulses_b", 32'(csec), 3);

        // seconds rollover and sec_pulse
        pulses(96 * P + 3);
        check_time("pre_sec", 0, 0, 99);
        check("pre_sec.sec_pulse", 32'(sec_pulse), 0);
        pulses(1);
        check_time("sec_roll", 0, 1, 0);
        check("sec_roll.sec_pulse", 32'(sec_pulse), 1);
        @(negedge clk);
        check("sec_pulse_one_cycle", 32'(sec_pulse), 0);

        // lap freeze
        pulses(20 * P);
        check_time("pre_lap", 0, 1, 20);
        drive(0, 1, 0, 0);
        check("lap.active", 32'(lap_active), 1);
        pulses(50 * P);
        check_time("lap_frozen", 0, 1, 20);
        drive(0, 1, 0, 0);
        check("lap_release.active", 32'(lap_active), 0);
        check_time("lap_release", 0, 1, 70);

        // lap persists across pause; lap in PAUSE ignored
        drive(0, 1, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        check("lap_in_pause_ignored", 32'(lap_active), 1);
        drive(1, 0, 0, 0);
        check("lap_persist_run", 32'(lap_active), 1);
        drive(0, 1, 0, 0);
        check("lap_off", 32'(lap_active), 0);

        // minute rollover from 00:01.70
        pulses(5830 * P - 1);
        check_time("pre_min", 0, 59, 99);
        pulses(1);
        check_time("min_roll", 1, 0, 0);

        // clear beats start/lap/usec in same cycle
        drive(1, 1, 1, 1);
        check_time("clear", 0, 0, 0);
        check("clear.running", 32'(running), 0);
        check("clear.lap", 32'(lap_active), 0);
        pulses(10);
        check_time("clear_idle", 0, 0, 0);

        // reset mid-run at 00:03.47
        drive(1, 0, 0, 0);
        pulses(347 * P);
        check_time("pre_reset", 0, 3, 47);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_time("async_reset", 0, 0, 0);
        check("async_reset.running", 32'(running), 0);
        @(negedge clk);
        reset = 1'b0;
        pulses(1000);
        check_time("post_reset_idle", 0, 0, 0);
        check("post_reset.running", 32'(running), 0);
        drive(1, 0, 0, 0);
        pulses(P);
        check("restart_count", 32'(csec), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter: USEC_PER_CSEC, default 10000, clk_usec pulses per centisecond (legal 1..16383).
REQ-002 clk  input  1  system clock, 100 MHz.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clk_usec  input  1  one-clk-cycle pulse once per microsecond, synchronous to clk, from the upstream microsecond tick generator.
REQ-005 btn_start_stop  input  1  debounced single-cycle pulse; toggles run/pause.
REQ-006 btn_lap  input  1  debounced single-cycle pulse; toggles lap freeze.
REQ-007 btn_clear  input  1  debounced single-cycle pulse; returns to zero/idle.
REQ-008 min  output  6  displayed minutes, 0..59.
REQ-009 sec  output  6  displayed seconds, 0..59.
REQ-010 csec  output  7  displayed centiseconds, 0..99.
REQ-011 running  output  1  high while state is RUN.
REQ-012 lap_active  output  1  high while the display is frozen.
REQ-013 sec_pulse  output  1  one-cycle pulse when the internal seconds count advances.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and PAUSE.
REQ-015 btn_start_stop SHALL move IDLE->RUN, RUN->PAUSE and PAUSE->RUN on the clock edge sampling it.
REQ-016 btn_clear SHALL move any state to IDLE, zero the prescaler and all time counters, and clear lap_active on the same edge.
REQ-017 btn_clear SHALL take priority over btn_start_stop and btn_lap asserted in the same cycle; those pulses SHALL be discarded.
REQ-018 Counting SHALL occur only in RUN and only on cycles where clk_usec=1.
REQ-019 Prescaler SHALL count 0..USEC_PER_CSEC-1; a pulse at terminal count SHALL wrap it to 0 and increment csec on the same edge.
REQ-020 csec 99->0 SHALL increment sec; sec 59->0 SHALL increment min; 59:59.99 SHALL wrap to 00:00.00 and counting SHALL continue.
REQ-021 The prescaler and counters SHALL hold (no loss of sub-centisecond time) in PAUSE.
REQ-022 A clk_usec pulse in the same cycle as a RUN->PAUSE transition SHALL still be counted; a pulse coincident with PAUSE->RUN or IDLE->RUN SHALL NOT be counted.
REQ-023 btn_lap in RUN SHALL toggle lap_active; setting it SHALL capture the live min/sec/csec into a hold register on that edge.
REQ-024 btn_lap in IDLE or PAUSE SHALL be ignored; lap_active SHALL persist across RUN/PAUSE transitions.
REQ-025 Outputs min/sec/csec SHALL show the hold register while lap_active=1, else the live counters, with zero cycles of added latency beyond the counter register.
REQ-026 sec_pulse SHALL be high for exactly the one cycle after the edge on which the internal sec counter changes by increment (not by clear), independent of lap_active.
REQ-027 running SHALL be a registered decode of state RUN.

Reset
REQ-028 reset SHALL asynchronously force state IDLE, prescaler 0, min=sec=csec=0, hold register 0, running=0, lap_active=0, sec_pulse=0.
REQ-029 reset asserted mid-RUN SHALL discard all accumulated time; after release the block SHALL stay in IDLE until btn_start_stop.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding and constants CSEC_MAX=99, SEC_MAX=59, MIN_MAX=59.
REQ-031 One sub-module, counter_modn (parameterised modulus, enable in, synchronous clear, carry out), SHALL implement the prescaler and each time digit stage.

Verification
REQ-032 Reset mid-RUN at 00:03.47 -> all outputs 0, running=0; 1000 clk_usec pulses after release -> still 00:00.00.
REQ-033 Default parameter, start, 10000 pulses -> csec=1; further 990000 pulses -> sec=1, csec=0, one sec_pulse seen.
REQ-034 Start, 5000 pulses, pause, 20000 pulses, start, 5000 pulses -> csec=1, sec=0.
REQ-035 USEC_PER_CSEC=1, start, 360000 pulses -> 00:00.00 with running=1; pulse 360001 -> csec=1.
REQ-036 Run to 00:01.20, lap -> display frozen at 00:01.20 while 50 more csec elapse; lap again -> display 00:01.70.
REQ-037 btn_clear and btn_start_stop in same cycle during RUN -> IDLE, 00:00.00, running=0, lap_active=0.
